// File: rtl/walk_pkg.sv
// Shared walk-request definitions: FSM state encoding, default sizing and width helper.
// Also reused by the traffic-light controller, so the state encoding must stay fixed.
package walk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_SERVE = 2'd2
  } walk_state_t;

  localparam int WALK_N_CH     = 4;
  localparam int WALK_AGE_W    = 8;
  localparam int WALK_WAIT_MAX = 200;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/walk_rr_arbiter.sv
// Combinational round-robin picker: urgent channels take precedence over merely pending ones.
// Zero latency; the search begins at rr_ptr and wraps from N_CH-1 back to 0.
module walk_rr_arbiter
  import walk_pkg::*;
#(
  parameter int N_CH = WALK_N_CH,
  parameter int CH_W = ch_width(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [N_CH-1:0] urg,
  input  logic [CH_W-1:0] rr_ptr,
  output logic            found,
  output logic [CH_W-1:0] index
);

  logic [N_CH-1:0] cand;
  int              pos;

  // Scan from farthest to nearest, so the nearest hit is the last assignment made.
  always_comb begin
    cand  = (|urg) ? urg : req;
    found = 1'b0;
    index = '0;
    pos   = 0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      pos = (int'(rr_ptr) + k) % N_CH;
      if (cand[pos]) begin
        found = 1'b1;
        index = pos[CH_W-1:0];
      end
    end
  end

endmodule

// File: rtl/walk_request_bank.sv
// Latches pedestrian walk requests, ages them, and offers one channel at a time to the controller.
// Requests are visible 1 cycle after WR_Sync; a grant holds until Srv_Ready, and service holds until Srv_Done or a cancel.
module walk_request_bank
  import walk_pkg::*;
#(
  parameter  int N_CH     = WALK_N_CH,
  parameter  int AGE_W    = WALK_AGE_W,
  parameter  int WAIT_MAX = WALK_WAIT_MAX,
  localparam int CH_W     = ch_width(N_CH)
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [N_CH-1:0] WR_Sync,
  input  logic [N_CH-1:0] WR_Clear,
  input  logic            Srv_Ready,
  input  logic            Srv_Done,
  output logic [N_CH-1:0] WR,
  output logic [N_CH-1:0] Urgent,
  output logic            Grant_Valid,
  output logic [CH_W-1:0] Grant_Ch,
  output logic            Busy
);

  walk_state_t     state_q, state_d;
  logic [N_CH-1:0] wr_q, wr_d, urgent_q, urgent_d;
  logic [AGE_W-1:0] age_q [N_CH];
  logic [AGE_W-1:0] age_d [N_CH];
  logic [CH_W-1:0] grant_ch_q, grant_ch_d, rr_ptr_q, rr_ptr_d;
  logic            arb_found;
  logic [CH_W-1:0] arb_idx;
  logic            serving, abort, done, own;

  assign serving = (state_q == ST_SERVE);
  assign abort   = (state_q != ST_IDLE) && WR_Clear[grant_ch_q];
  assign done    = serving && Srv_Done && !abort;

  // A channel being cancelled this cycle is never offered.
  walk_rr_arbiter #(.N_CH(N_CH), .CH_W(CH_W)) u_arb (
    .req    (wr_q & ~WR_Clear),
    .urg    (urgent_q & ~WR_Clear),
    .rr_ptr (rr_ptr_q),
    .found  (arb_found),
    .index  (arb_idx)
  );

  always_comb begin
    wr_d     = wr_q;
    urgent_d = '0;
    age_d    = age_q;
    own      = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      // The channel under service neither re-latches presses nor ages.
      own = serving && (grant_ch_q == CH_W'(i));
      if (WR_Clear[i] || (own && done)) begin
        wr_d[i] = 1'b0;
      end else if (WR_Sync[i] && !own) begin
        wr_d[i] = 1'b1;
      end
      if (!wr_d[i]) begin
        age_d[i] = '0;
      end else if (wr_q[i] && !own && (age_q[i] != '1)) begin
        age_d[i] = age_q[i] + 1'b1;
      end
      urgent_d[i] = wr_d[i] && (age_d[i] >= AGE_W'(WAIT_MAX));
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_ch_d = grant_ch_q;
    rr_ptr_d   = rr_ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          state_d    = ST_GRANT;
          grant_ch_d = arb_idx;
        end
      end
      ST_GRANT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (Srv_Ready) begin
          state_d = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (Srv_Done) begin
          state_d  = ST_IDLE;
          rr_ptr_d = (grant_ch_q == CH_W'(N_CH - 1)) ? '0 : grant_ch_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      wr_q       <= '0;
      urgent_q   <= '0;
      grant_ch_q <= '0;
      rr_ptr_q   <= '0;
      for (int i = 0; i < N_CH; i++) age_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      urgent_q   <= urgent_d;
      grant_ch_q <= grant_ch_d;
      rr_ptr_q   <= rr_ptr_d;
      for (int i = 0; i < N_CH; i++) age_q[i] <= age_d[i];
    end
  end

  assign WR          = wr_q;
  assign Urgent      = urgent_q;
  assign Grant_Valid = (state_q == ST_GRANT);
  assign Busy        = serving;
  assign Grant_Ch    = grant_ch_q;

endmodule

// File: doc/walk_request_bank.md
WALK_REQUEST_BANK -- requirements
Module: walk_request_bank

Interface
REQ-001 Parameter N_CH, default 4: number of pedestrian crossing channels, range 2..16.
REQ-002 Parameter AGE_W, default 8: width of each per-channel wait-age counter.
REQ-003 Parameter WAIT_MAX, default 200: age at which a pending request becomes urgent; SHALL be less than 2^AGE_W.
REQ-004 Derived constant CH_W = clog2(N_CH), minimum 1.
REQ-005 Clk  input  1  single clock; all state updates on the rising edge.
REQ-006 Reset  input  1  reset; asynchronous, active-high.
REQ-007 WR_Sync  input  N_CH  synchronised request pulse per channel; sampled on each rising edge of Clk.
REQ-008 WR_Clear  input  N_CH  per-channel request cancel, level-sampled.
REQ-009 Srv_Ready  input  1  controller accepts the offered grant.
REQ-010 Srv_Done  input  1  controller finished the walk phase for the granted channel.
REQ-011 WR  output  N_CH  per-channel pending-request flags.
REQ-012 Urgent  output  N_CH  per-channel flag: pending and age >= WAIT_MAX.
REQ-013 Grant_Valid  output  1  grant offered (GRANT state only).
REQ-014 Grant_Ch  output  CH_W  channel being offered or served.
REQ-015 Busy  output  1  high in SERVE state.

Function
REQ-016 WR[i] SHALL set on the edge sampling WR_Sync[i]=1; visible the following cycle (1-cycle latency).
REQ-017 WR[i] SHALL clear on the edge sampling WR_Clear[i]=1; WR_Clear wins over WR_Sync in the same cycle.
REQ-018 Age[i] SHALL increment by 1 per cycle while WR[i]=1 and channel i is not Grant_Ch in SERVE, saturating at 2^AGE_W-1; it SHALL reset to 0 whenever WR[i] clears.
REQ-019 Urgent[i] SHALL be registered: WR[i] and Age[i] >= WAIT_MAX.
REQ-020 FSM states: IDLE, GRANT, SERVE.
REQ-021 IDLE: if any WR bit set, select a channel, load Grant_Ch, go to GRANT next edge; otherwise stay.
REQ-022 Selection: if any Urgent bit set, round-robin among urgent channels only; else round-robin among pending channels; search starts at rr_ptr, ascending, wrapping N_CH-1 -> 0.
REQ-023 GRANT: Grant_Valid=1, Grant_Ch held stable; Srv_Ready=1 -> SERVE; Srv_Done ignored.
REQ-024 SERVE: Busy=1; WR_Sync on Grant_Ch ignored (including the Srv_Done cycle); other channels latch normally.
REQ-025 SERVE with Srv_Done=1: clear WR[Grant_Ch], set rr_ptr = (Grant_Ch+1) mod N_CH, go to IDLE.
REQ-026 WR_Clear on Grant_Ch in GRANT or SERVE SHALL abort: clear WR, go to IDLE, Grant_Valid/Busy low next cycle, rr_ptr unchanged.
REQ-027 Minimum IDLE dwell of 1 cycle between services; back-to-back grants to the same channel are permitted only if it is the sole pending channel.
REQ-028 Grant_Ch SHALL hold its last value while in IDLE.

Reset
REQ-029 Reset asserted SHALL immediately force WR=0, Urgent=0, Grant_Valid=0, Busy=0, Grant_Ch=0, all ages 0, rr_ptr=0, state IDLE.
REQ-030 Reset mid-GRANT or mid-SERVE SHALL discard the service without rr_ptr update; first post-reset grant searches from channel 0.
REQ-031 Inputs SHALL be ignored while Reset is high; operation resumes on the first edge after deassertion.

Structure
REQ-032 State encoding (IDLE=0, GRANT=1, SERVE=2) and default parameter constants SHALL live in shared package/include walk_pkg, reused by the traffic-light controller.
REQ-033 Selection logic (REQ-022) SHALL be a combinational sub-module walk_rr_arbiter (inputs request vector, urgent vector, rr_ptr; outputs found, index).
REQ-034 Pending flags, ages, FSM and rr_ptr SHALL reside in walk_request_bank; no latches, no combinational output paths from inputs.

Verification
REQ-035 Single request: N_CH=4, pulse WR_Sync[2] at cycle 10 -> WR=0100 at 11, Grant_Valid=1, Grant_Ch=2 at 12; Srv_Ready at 13 -> Busy at 14; Srv_Done at 20 -> WR=0000, IDLE at 21.
REQ-036 Round-robin: WR_Sync=1011 together, Srv_Ready/Srv_Done asserted promptly -> service order 0,1,3; then new request on 0 and 1 -> order 1 before... no: rr_ptr=0 after 3, order 0,1.
REQ-037 Urgency: WAIT_MAX=5, request ch1 held pending through a long ch0 service, ch2 requested after -> Urgent[1]=1 after 5 pending cycles; next grant is ch1 even if rr_ptr points to ch2.
REQ-038 Cancel/abort: in SERVE on ch3, WR_Clear[3]=1 -> WR[3]=0, Busy=0 next cycle, rr_ptr unchanged; simultaneous WR_Sync[1] and WR_Clear[1] -> WR[1] stays 0.
REQ-039 Re-press during walk: WR_Sync[2] during SERVE on ch2 and on Srv_Done cycle -> WR[2]=0 after Srv_Done; age saturation: AGE_W=3 holds at 7.
REQ-040 Async reset: assert Reset mid-clock-cycle during SERVE -> all outputs 0 before next edge; after release, request on ch3 and ch1 -> ch1 granted first.
